// File: rtl/zigzag_runlevel_4x4_if.sv
// rtl/zigzag_runlevel_4x4_if.sv - block-in / run-level-out bundle for the 4x4 zigzag scanner
interface zigzag_runlevel_4x4_if #(
  parameter int BIT_LENGTH = 15
);
  logic [BIT_LENGTH:0] quantized [15:0];
  logic                in_valid;
  logic                in_ready;
  logic [BIT_LENGTH:0] out_level;
  logic [3:0]          out_run;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;
  logic                blk_done;
  logic [4:0]          total_coeffs;
  logic [3:0]          total_zeros;
  logic [1:0]          trailing_ones;

  modport master (
    output quantized, in_valid, out_ready,
    input  in_ready, out_level, out_run, out_last, out_valid,
    input  blk_done, total_coeffs, total_zeros, trailing_ones
  );

  modport slave (
    input  quantized, in_valid, out_ready,
    output in_ready, out_level, out_run, out_last, out_valid,
    output blk_done, total_coeffs, total_zeros, trailing_ones
  );
endinterface

// File: rtl/zigzag_runlevel_4x4.sv
// rtl/zigzag_runlevel_4x4.sv - 4x4 zigzag reorder to (level, run) pairs with CAVLC block summary
module zigzag_runlevel_4x4 #(
  parameter int BIT_LENGTH = 15
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  enable,
  zigzag_runlevel_4x4_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [BIT_LENGTH:0] COEF_ONE = {{BIT_LENGTH{1'b0}}, 1'b1};

  state_t              state;
  logic [BIT_LENGTH:0] coef [15:0];
  logic [15:0]         mask;
  logic [3:0]          last_pos;
  logic [3:0]          idx;
  logic [3:0]          run;
  logic [4:0]          count;
  logic [4:0]          streak;
  logic [4:0]          total_coeffs_q;
  logic [3:0]          total_zeros_q;
  logic [1:0]          trailing_ones_q;

  function automatic logic [3:0] zz(input logic [3:0] p);
    case (p)
      4'd0:    zz = 4'd0;
      4'd1:    zz = 4'd1;
      4'd2:    zz = 4'd4;
      4'd3:    zz = 4'd8;
      4'd4:    zz = 4'd5;
      4'd5:    zz = 4'd2;
      4'd6:    zz = 4'd3;
      4'd7:    zz = 4'd6;
      4'd8:    zz = 4'd9;
      4'd9:    zz = 4'd12;
      4'd10:   zz = 4'd13;
      4'd11:   zz = 4'd10;
      4'd12:   zz = 4'd7;
      4'd13:   zz = 4'd11;
      4'd14:   zz = 4'd14;
      default: zz = 4'd15;
    endcase
  endfunction

  // mask is kept in raster order; last_pos is found in scan order
  logic [15:0] mask_in;
  logic [3:0]  last_pos_in;
  always_comb begin
    mask_in     = '0;
    last_pos_in = '0;
    for (int i = 0; i < 16; i++) mask_in[i] = |bus.quantized[i];
    for (int p = 0; p < 16; p++) if (mask_in[zz(4'(p))]) last_pos_in = 4'(p);
  end

  logic [3:0]          cur_i;
  logic [BIT_LENGTH:0] cur;
  logic                cur_nz;
  logic                cur_one;
  logic                cur_last;
  logic [4:0]          count_nx;
  logic [4:0]          streak_nx;

  assign cur_i     = zz(idx);
  assign cur       = coef[cur_i];
  assign cur_nz    = mask[cur_i];
  assign cur_one   = (cur == COEF_ONE) || (cur == '1);
  assign cur_last  = (idx == last_pos);
  assign count_nx  = count + 5'd1;
  assign streak_nx = cur_one ? streak + 5'd1 : 5'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      for (int i = 0; i < 16; i++) coef[i] <= '0;
      mask            <= '0;
      last_pos        <= '0;
      idx             <= '0;
      run             <= '0;
      count           <= '0;
      streak          <= '0;
      total_coeffs_q  <= '0;
      total_zeros_q   <= '0;
      trailing_ones_q <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            coef     <= bus.quantized;
            mask     <= mask_in;
            last_pos <= last_pos_in;
            idx      <= '0;
            run      <= '0;
            count    <= '0;
            streak   <= '0;
            if (|mask_in) begin
              state <= SCAN;
            end else begin
              state           <= DONE;
              total_coeffs_q  <= '0;
              total_zeros_q   <= '0;
              trailing_ones_q <= '0;
            end
          end
        end
        SCAN: begin
          if (!cur_nz) begin
            run <= run + 4'd1;
            idx <= idx + 4'd1;
          end else if (bus.out_ready) begin
            count  <= count_nx;
            streak <= streak_nx;
            run    <= '0;
            idx    <= idx + 4'd1;
            if (cur_last) begin
              // summary is latched on the final handshake so it is valid during DONE
              state           <= DONE;
              total_coeffs_q  <= count_nx;
              total_zeros_q   <= last_pos + 4'd1 - count_nx[3:0];
              trailing_ones_q <= (streak_nx > 5'd3) ? 2'd3 : streak_nx[1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = enable && (state == IDLE);
  assign bus.out_valid     = enable && (state == SCAN) && cur_nz;
  assign bus.out_level     = (state == SCAN) ? cur : '0;
  assign bus.out_run       = (state == SCAN) ? run : '0;
  assign bus.out_last      = (state == SCAN) && cur_nz && cur_last;
  assign bus.blk_done      = enable && (state == DONE);
  assign bus.total_coeffs  = total_coeffs_q;
  assign bus.total_zeros   = total_zeros_q;
  assign bus.trailing_ones = trailing_ones_q;
endmodule

// File: tb/tb_zigzag_runlevel_4x4.sv
// tb/tb_zigzag_runlevel_4x4.sv - scoreboard bench for the 4x4 zigzag run-level scanner
module tb_zigzag_runlevel_4x4;
  localparam int BL = 15;
  localparam int W  = BL + 1;
  localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  logic clk = 1'b0;
  logic reset;
  logic enable;

  zigzag_runlevel_4x4_if #(.BIT_LENGTH(BL)) bus ();

  zigzag_runlevel_4x4 #(.BIT_LENGTH(BL)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct { int level; int run; bit last; int cyc; } pair_t;
  typedef struct { int tc; int tz; int t1; int cyc; } sum_t;

  pair_t pair_q[$];
  sum_t  sum_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    edge_n = 0;
  int    pairs_seen = 0;
  bit    stress = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the block in scan order and emit pairs; summary from the pair list.
  task automatic model(input int blk[16], input int t0, input bit timed);
    pair_t tmp[$];
    pair_t p;
    sum_t  s;
    int    zeros = 0;
    int    lastp = -1;
    int    ones = 0;
    int    v;
    for (int i = 0; i < 16; i++) begin
      v = blk[ZZ[i]];
      if (v == 0) begin
        zeros++;
      end else begin
        p.level = v;
        p.run   = zeros;
        p.last  = 0;
        p.cyc   = timed ? t0 + 1 + i : -1;
        tmp.push_back(p);
        zeros = 0;
        lastp = i;
      end
    end
    if (tmp.size() > 0) tmp[tmp.size() - 1].last = 1;
    foreach (tmp[k]) pair_q.push_back(tmp[k]);
    for (int k = tmp.size() - 1; k >= 0; k--) begin
      if (tmp[k].level != 1 && tmp[k].level != -1) break;
      ones++;
    end
    s.tc  = tmp.size();
    s.tz  = (lastp < 0) ? 0 : lastp + 1 - tmp.size();
    s.t1  = (ones > 3) ? 3 : ones;
    s.cyc = timed ? ((lastp < 0) ? t0 + 1 : t0 + 2 + lastp) : -1;
    sum_q.push_back(s);
  endtask

  // Monitor: pops the scoreboard on each handshake / blk_done.
  bit              hold = 0;
  logic [BL:0]     hold_level;
  logic [3:0]      hold_run;
  logic            hold_last;
  pair_t           ep;
  sum_t            es;

  always @(negedge clk) begin
    if (reset) begin
      if (!enable) check("freeze_outputs", {bus.out_valid, bus.in_ready, bus.blk_done}, 0);
      if (bus.out_valid) begin
        check("valid_nonzero", (bus.out_level != 0), 1);
        if (hold) check("hold_stable", {bus.out_level, bus.out_run, bus.out_last},
                        {hold_level, hold_run, hold_last});
        hold       = !bus.out_ready;
        hold_level = bus.out_level;
        hold_run   = bus.out_run;
        hold_last  = bus.out_last;
        if (bus.out_ready) begin
          if (pair_q.size() == 0) begin
            check("unexpected_pair", 1, 0);
          end else begin
            ep = pair_q.pop_front();
            check("pair_level", $signed(bus.out_level), ep.level);
            check("pair_run", bus.out_run, ep.run);
            check("pair_last", bus.out_last, ep.last);
            if (ep.cyc >= 0) check("pair_cycle", edge_n, ep.cyc);
            pairs_seen++;
          end
        end
      end else if (enable) begin
        hold = 0;
      end
      if (bus.blk_done) begin
        if (sum_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          es = sum_q.pop_front();
          check("total_coeffs", bus.total_coeffs, es.tc);
          check("total_zeros", bus.total_zeros, es.tz);
          check("trailing_ones", bus.trailing_ones, es.t1);
          if (es.cyc >= 0) check("done_cycle", edge_n, es.cyc);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (stress) begin
      #1;
      bus.out_ready = ($urandom % 4) != 0;
      enable        = ($urandom % 5) != 0;
    end
  end

  task automatic send(input int blk[16], input bit timed, input bit wait_done);
    int t0 = -1;
    bit done = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) bus.quantized[i] = W'(blk[i]);
    bus.in_valid = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        t0 = edge_n;
        break;
      end
    end
    if (t0 < 0) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 0;
      return;
    end
    model(blk, t0, timed);
    @(posedge clk);
    #1;
    // junk offered while busy must be ignored
    for (int i = 0; i < 16; i++) bus.quantized[i] = W'($urandom);
    if (!wait_done) return;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.blk_done) begin
        done = 1;
        break;
      end
    end
    bus.in_valid = 0;
    if (!done) check("done_timeout", 0, 1);
  endtask

  function automatic int rnd_coef(input int dens);
    int r;
    int v;
    if (int'($urandom % 100) >= dens) return 0;
    r = int'($urandom % 3);
    if (r == 0) v = 1;
    else if (r == 1) v = int'($urandom_range(2, 5));
    else v = int'($urandom_range(1, 32767));
    return ($urandom % 2) ? -v : v;
  endfunction

  int b[16];
  int start;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 0;
    enable        = 1;
    bus.in_valid  = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 16; i++) bus.quantized[i] = '0;
    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_blk_done", bus.blk_done, 0);
    check("rst_summary", {bus.total_coeffs, bus.total_zeros, bus.trailing_ones}, 0);
    check("rst_in_ready", bus.in_ready, 1);
    #14 reset = 1;

    b = '{default: 0}; b[0] = 5; b[1] = -1; b[4] = 1;
    send(b, 1, 1);
    b = '{default: 0}; b[15] = -3;
    send(b, 1, 1);
    b = '{default: 0};
    send(b, 1, 1);
    b = '{default: 0}; b[0] = 1; b[1] = -1; b[4] = 1; b[8] = -1; b[5] = 1; b[3] = 7;
    send(b, 1, 1);
    b = '{default: 0}; b[0] = 1; b[1] = -1; b[4] = 1; b[8] = -1; b[5] = 1;
    send(b, 1, 1);
    for (int i = 0; i < 16; i++) b[i] = 1;
    send(b, 1, 1);

    // backpressure on the first pair
    b = '{default: 0}; b[0] = 9; b[2] = -2; b[12] = 1;
    bus.out_ready = 0;
    fork
      send(b, 0, 1);
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (bus.out_valid) break;
        end
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join

    // enable drop mid-scan
    for (int i = 0; i < 16; i++) b[i] = (i % 3 == 0) ? i + 2 : 0;
    fork
      send(b, 0, 1);
      begin
        repeat (5) @(posedge clk);
        #1 enable = 0;
        repeat (2) @(posedge clk);
        #1 enable = 1;
      end
    join

    // reset after the 2nd pair
    for (int i = 0; i < 16; i++) b[i] = i + 1;
    start = pairs_seen;
    send(b, 0, 0);
    bus.in_valid = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (pairs_seen >= start + 2) break;
    end
    #2 reset = 0;
    pair_q.delete();
    sum_q.delete();
    hold = 0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_blk_done", bus.blk_done, 0);
    check("midrst_summary", {bus.total_coeffs, bus.total_zeros, bus.trailing_ones}, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1;
    repeat (3) @(posedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    b = '{default: 0}; b[6] = -1; b[9] = 4;
    send(b, 1, 1);

    for (int n = 0; n < 40; n++) begin
      int dens;
      dens = int'($urandom_range(0, 100));
      for (int i = 0; i < 16; i++) b[i] = rnd_coef(dens);
      if (n == 20) stress = 1;
      send(b, 0, 1);
    end
    stress = 0;
    @(posedge clk);
    #2;
    enable        = 1;
    bus.out_ready = 1;
    repeat (5) @(negedge clk);
    check("scoreboard_empty", pair_q.size() + sum_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/zigzag_runlevel_4x4.md
Name: zigzag_runlevel_4x4

Overview:
- Consumes one 4x4 block of quantized coefficients from the quantizer output of the transform-coding path.
- Reorders the block in 4x4 frame zigzag order and serializes it as (level, run) pairs on a valid/ready stream for the entropy coder.
- Emits per-block CAVLC summary values: total nonzero coefficients, total zeros, and trailing ones.

Parameters:
- BIT_LENGTH, 15, MSB index of each coefficient; coefficients are BIT_LENGTH+1 bits, two's complement.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  global advance; when low, all registers hold.
- quantized  input  [BIT_LENGTH:0] x16 (unpacked [15:0])  coefficients, index = row*4+col.
- in_valid  input  1  quantized block is valid.
- in_ready  output  1  block accepted when in_valid && in_ready.
- out_level  output  BIT_LENGTH+1  signed nonzero coefficient.
- out_run  output  4  count of zeros preceding out_level in scan order since the previous nonzero (or block start).
- out_last  output  1  marks the final nonzero pair of the block.
- out_valid  output  1  pair valid.
- out_ready  input  1  consumer accepts pair.
- blk_done  output  1  one-cycle pulse; summary outputs are valid.
- total_coeffs  output  5  nonzero count, 0..16.
- total_zeros  output  4  zeros before the last nonzero in scan order, 0..15.
- trailing_ones  output  2  trailing ±1 count, 0..3.

Behaviour:
- Zigzag scan position p=0..15 maps to index 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0, except in_ready, which follows the IDLE/enable rule below.
  - Coefficient bank, run counter, scan index and all summary registers cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = enable.
  - On in_valid && in_ready, register all 16 coefficients and the nonzero mask.
  - Also compute last_pos, the highest scan position holding a nonzero.
  - Clear idx, run, count and ones-streak.
  - Next state: SCAN if the mask is nonzero, else DONE.
- SCAN (one scan position per cycle):
  - Examine coefficient c at position idx.
  - c==0: run++, idx++, out_valid=0.
  - c!=0: out_valid=1, out_level=c, out_run=run, out_last=(idx==last_pos). Pair outputs are held stable until out_ready.
  - On the c!=0 handshake: count++; streak = (|c|==1) ? streak+1 : 0; run=0; idx++.
  - The handshake with out_last=1 moves the FSM to DONE.
- DONE:
  - blk_done=1 for exactly one cycle, then IDLE.
  - total_coeffs = count.
  - total_zeros = last_pos+1-count; 0 for an all-zero block.
  - trailing_ones = min(streak,3).
  - Summary outputs hold until the next DONE.
- enable=0:
  - No state or register changes.
  - in_ready=0, out_valid=0, blk_done=0.
  - Pair-output contents are held.
  - No handshake can complete.
- Latency, with block accepted at edge T0 and no stalls:
  - The pair for scan position p is valid in cycle T0+1+p.
  - DONE occurs in the cycle after the last handshake.
  - An all-zero block gives blk_done in cycle T0+1.
  - in_ready returns the cycle after DONE.
  - Worst case is 18 cycles per block.
- Input is never accepted outside IDLE; in_valid during SCAN/DONE is ignored (not captured).
- out_valid is never asserted without a nonzero level.
- Outputs derive only from registered state and enable; there is no combinational path from out_ready or in_valid to any output.
- Reset mid-block aborts immediately: no further pairs, no blk_done, IDLE on release.

Test Plan:
- Reset behaviour: assert reset mid-cycle with enable=1 -> out_valid=0, blk_done=0, all summary outputs 0, in_ready=1 after release.
- Basic block: quantized[0]=5, [1]=-1, [4]=1, rest 0 -> pairs (5,0), (-1,0), (1,0,last) in cycles T0+1..T0+3; blk_done at T0+4 with total_coeffs=3, total_zeros=0, trailing_ones=2.
- Sparse block: only quantized[15]=-3 -> single pair (-3,15,last) at T0+16; blk_done at T0+17 with total_coeffs=1, total_zeros=15, trailing_ones=0.
- All-zero block -> no out_valid; blk_done at T0+1 with all totals 0. Second case: ±1 at indices 0,1,4,8,5 plus 7 at index 3 -> trailing_ones=3 counted before the 7 resets the streak, ending with streak 0 -> trailing_ones=0.
- Backpressure and freeze:
  - Hold out_ready=0 for 3 cycles on the first pair -> level and run stable, idx frozen.
  - Drop enable for 2 cycles mid-scan -> no state change, out_valid=0; sequence resumes identically.
- Reset during SCAN after the 2nd pair -> no further pairs, no blk_done; a new block is accepted after release.
